// File: rtl/imm_gen_seq.sv
// Immediate generator: decodes a 16-bit word into a sign-extended XLEN immediate, with optional 13-bit prefix extension.
// One-cycle latency through a single output register; in_ready drops only while that register is full and unconsumed.
module imm_gen_seq #(
  parameter int XLEN   = 16,
  parameter bit PFX_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     instr,
  input  logic            in_pfx,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      out_type,
  output logic            pfx_err
);

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_M = 3'd2;
  localparam logic [2:0] T_Y = 3'd3;
  localparam logic [2:0] T_J = 3'd4;

  typedef enum logic {IDLE, HELD} state_t;

  state_t          r_state;
  logic [12:0]     r_pfx;
  logic            r_out_valid;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_type;
  logic            r_pfx_err;

  logic            w_accept;
  logic            w_is_pfx;
  logic [2:0]      w_type;
  logic [3:0]      w_k;
  logic [XLEN-1:0] w_fsext;
  logic [XLEN-1:0] w_fzext;
  logic [XLEN-1:0] w_pfx_sext;
  logic [XLEN-1:0] w_imm_next;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_is_pfx  = PFX_EN && in_pfx;

  assign out_valid = r_out_valid;
  assign imm       = r_imm;
  assign out_type  = r_type;
  assign pfx_err   = r_pfx_err;

  always_comb begin
    w_type  = T_R;
    w_k     = 4'd4;
    w_fsext = {{(XLEN-4){instr[3]}}, instr[3:0]};
    w_fzext = {{(XLEN-4){1'b0}}, instr[3:0]};
    case (instr[15:13])
      3'b000: ;
      3'b001: begin
        w_type  = T_I;
        w_fsext = {{(XLEN-4){instr[5]}}, instr[5:2]};
        w_fzext = {{(XLEN-4){1'b0}}, instr[5:2]};
      end
      3'b010, 3'b011: begin
        w_type  = T_M;
        w_k     = 4'd7;
        w_fsext = {{(XLEN-7){instr[6]}}, instr[6:0]};
        w_fzext = {{(XLEN-7){1'b0}}, instr[6:0]};
      end
      3'b100, 3'b101: begin
        w_type  = T_Y;
        w_k     = 4'd13;
        w_fsext = {{(XLEN-13){instr[12]}}, instr[12:0]};
        w_fzext = {{(XLEN-13){1'b0}}, instr[12:0]};
      end
      default: begin
        w_type  = T_J;
        w_k     = 4'd13;
        w_fsext = {{(XLEN-13){instr[12]}}, instr[12:0]};
        w_fzext = {{(XLEN-13){1'b0}}, instr[12:0]};
      end
    endcase
  end

  // Prefix supplies the upper bits; the field fills the low k bits unsigned.
  assign w_pfx_sext = {{(XLEN-13){r_pfx[12]}}, r_pfx};
  assign w_imm_next = (r_state == HELD) ? ((w_pfx_sext << w_k) | w_fzext) : w_fsext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pfx       <= '0;
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_type      <= T_R;
      r_pfx_err   <= 1'b0;
    end else begin
      r_pfx_err <= 1'b0;
      if (flush) begin
        r_state     <= IDLE;
        r_pfx       <= '0;
        r_out_valid <= 1'b0;
      end else if (w_accept && w_is_pfx) begin
        r_pfx       <= instr[12:0];
        r_state     <= HELD;
        r_pfx_err   <= (r_state == HELD);
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_imm       <= w_imm_next;
        r_type      <= w_type;
        r_out_valid <= 1'b1;
        r_state     <= IDLE;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_seq.sv
// Drives an XLEN=16 and an XLEN=32 instance in lockstep and checks both against an arithmetic reference model.
module tb_imm_gen_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_pfx, flush, out_ready;
  logic [15:0] instr;
  logic        rdy16, rdy32, vld16, vld32, err16, err32;
  logic [15:0] imm16;
  logic [31:0] imm32;
  logic [2:0]  typ16, typ32;

  imm_gen_seq #(.XLEN(16), .PFX_EN(1'b1)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .instr(instr),
    .in_pfx(in_pfx), .flush(flush), .out_valid(vld16), .out_ready(out_ready),
    .imm(imm16), .out_type(typ16), .pfx_err(err16));

  imm_gen_seq #(.XLEN(32), .PFX_EN(1'b1)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .instr(instr),
    .in_pfx(in_pfx), .flush(flush), .out_valid(vld32), .out_ready(out_ready),
    .imm(imm32), .out_type(typ32), .pfx_err(err32));

  int n_vec = 0;
  int n_bad = 0;

  logic        m_vld, m_held, m_err;
  logic [12:0] m_pfx;
  longint      m_imm;
  int          m_type;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int type_of(input logic [15:0] ins);
    case (ins[15:13])
      3'd0:       return 0;
      3'd1:       return 1;
      3'd2, 3'd3: return 2;
      3'd4, 3'd5: return 3;
      default:    return 4;
    endcase
  endfunction

  // Signed value of the immediate as a plain integer; callers truncate to the width under test.
  function automatic longint calc(input logic [15:0] ins, input logic held, input logic [12:0] p);
    longint w, f, base;
    int k;
    w = longint'({48'd0, ins});
    case (ins[15:13])
      3'd0:       begin k = 4;  f = w & 15; end
      3'd1:       begin k = 4;  f = (w >> 2) & 15; end
      3'd2, 3'd3: begin k = 7;  f = w & 127; end
      default:    begin k = 13; f = w & 8191; end
    endcase
    if (!held)
      return (f >= (longint'(1) << (k - 1))) ? f - (longint'(1) << k) : f;
    base = longint'({51'd0, p});
    if (base >= 4096) base = base - 8192;
    return base * (longint'(1) << k) + f;
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_held = 1'b0; m_err = 1'b0; m_pfx = '0; m_imm = 0; m_type = 0;
  endtask

  task automatic model_step();
    logic acc;
    acc = in_valid && (!m_vld || out_ready);
    m_err = 1'b0;
    if (flush) begin
      m_vld = 1'b0; m_held = 1'b0;
    end else if (acc && in_pfx) begin
      m_err  = m_held;
      m_held = 1'b1;
      m_pfx  = instr[12:0];
      m_vld  = 1'b0;
    end else if (acc) begin
      m_imm  = calc(instr, m_held, m_pfx);
      m_type = type_of(instr);
      m_vld  = 1'b1;
      m_held = 1'b0;
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic check_all();
    logic exp_rdy;
    exp_rdy = !m_vld || out_ready;
    chk("rdy16", {63'd0, rdy16}, {63'd0, exp_rdy});
    chk("rdy32", {63'd0, rdy32}, {63'd0, exp_rdy});
    chk("vld16", {63'd0, vld16}, {63'd0, m_vld});
    chk("vld32", {63'd0, vld32}, {63'd0, m_vld});
    chk("err16", {63'd0, err16}, {63'd0, m_err});
    chk("err32", {63'd0, err32}, {63'd0, m_err});
    if (m_vld) begin
      chk("imm16", {48'd0, imm16}, {48'd0, m_imm[15:0]});
      chk("imm32", {32'd0, imm32}, {32'd0, m_imm[31:0]});
      chk("typ16", {61'd0, typ16}, 64'(m_type));
      chk("typ32", {61'd0, typ32}, 64'(m_type));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic apply(input logic v, input logic [15:0] ins, input logic p,
                       input logic f, input logic r);
    in_valid = v; instr = ins; in_pfx = p; flush = f; out_ready = r;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; in_pfx = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_vld", {63'd0, vld16}, 64'd0);
    chk("rst_imm16", {48'd0, imm16}, 64'd0);
    chk("rst_imm32", {32'd0, imm32}, 64'd0);
    chk("rst_typ", {61'd0, typ16}, 64'd0);
    chk("rst_err", {63'd0, err16}, 64'd0);
    chk("rst_rdy", {63'd0, rdy16}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain decode of each type, no prefix
    apply(1'b1, 16'h0008, 1'b0, 1'b0, 1'b1);
    chk("r_neg", {48'd0, imm16}, 64'hFFF8);
    chk("r_typ", {61'd0, typ16}, 64'd0);
    apply(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
    chk("r_pos", {48'd0, imm16}, 64'h0001);
    apply(1'b1, 16'h6040, 1'b0, 1'b0, 1'b1);
    chk("m_neg", {48'd0, imm16}, 64'hFFC0);
    chk("m_typ", {61'd0, typ16}, 64'd2);
    apply(1'b1, 16'h9000, 1'b0, 1'b0, 1'b1);
    chk("y_neg", {48'd0, imm16}, 64'hF000);
    chk("y_typ", {61'd0, typ16}, 64'd3);

    // Prefix then I: one output only
    apply(1'b1, 16'hC001, 1'b1, 1'b0, 1'b1);
    chk("pfx_noout", {63'd0, vld32}, 64'd0);
    apply(1'b1, 16'h2004, 1'b0, 1'b0, 1'b1);
    chk("pfx_imm32", {32'd0, imm32}, 64'h11);
    chk("pfx_typ", {61'd0, typ32}, 64'd1);
    apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("pfx_single", {63'd0, vld32}, 64'd0);

    // Backpressure hold, then back-to-back
    apply(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
      chk("stall_imm", {48'd0, imm16}, 64'h0003);
      chk("stall_rdy", {63'd0, rdy16}, 64'd0);
    end
    apply(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
    chk("b2b_1", {48'd0, imm16}, 64'h0005);
    apply(1'b1, 16'h0006, 1'b0, 1'b0, 1'b1);
    chk("b2b_2", {48'd0, imm16}, 64'h0006);
    chk("b2b_vld", {63'd0, vld16}, 64'd1);

    // Reset while a prefix is held
    apply(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("mid_rst_vld", {63'd0, vld16}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 16'h2020, 1'b0, 1'b0, 1'b1);
    chk("post_rst", {48'd0, imm16}, 64'hFFF8);

    // Prefix overwrite pulse and flush
    apply(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
    chk("err_hi", {63'd0, err16}, 64'd1);
    apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("err_lo", {63'd0, err16}, 64'd0);
    apply(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 16'h2004, 1'b0, 1'b0, 1'b1);
    chk("flush_pfx", {48'd0, imm16}, 64'h0001);
    apply(1'b1, 16'h0007, 1'b0, 1'b1, 1'b1);
    chk("flush_drop", {63'd0, vld16}, 64'd0);

    for (int i = 0; i < 2000; i++)
      apply($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
